// File: rtl/alu_request_driver_if.sv
// Operand/result bus between the request driver and a two-operand consumer.
// The driver streams two operand words under bus_rq and later samples bus_result.
interface alu_request_driver_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] bus_out;
    logic              bus_rq;
    logic [DATA_W-1:0] bus_result;

    modport master (
        output bus_out,
        output bus_rq,
        input  bus_result
    );

    modport slave (
        input  bus_out,
        input  bus_rq,
        output bus_result
    );
endinterface

// File: rtl/alu_request_driver.sv
// Drives one two-operand transaction onto a consumer bus, waits RESULT_WAIT
// edges after handing off operand B, then captures and reports the result.
module alu_request_driver #(
    parameter int RESULT_WAIT = 3,
    parameter int DATA_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [DATA_W-1:0]    op_a,
    input  logic [DATA_W-1:0]    op_b,
    alu_request_driver_if.master bus,
    output logic [DATA_W-1:0]    result,
    output logic                 done,
    output logic                 busy,
    output logic [7:0]           txn_count
);

    localparam int         RW_EFF    = (RESULT_WAIT < 1) ? 1 : RESULT_WAIT;
    localparam logic [3:0] WAIT_LOAD = 4'(RW_EFF - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND_A,
        S_SEND_B,
        S_WAIT,
        S_CAPTURE
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] op_b_q, op_b_d;
    logic [DATA_W-1:0] bus_out_q, bus_out_d;
    logic              bus_rq_q, bus_rq_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              done_q, done_d;
    logic [7:0]        txn_q, txn_d;

    // op_a needs no separate latch: bus_out holds it for the whole SEND_A cycle.
    always_comb begin
        state_d   = state_q;
        op_b_d    = op_b_q;
        bus_out_d = bus_out_q;
        bus_rq_d  = bus_rq_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        done_d    = 1'b0;
        txn_d     = txn_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_b_d    = op_b;
                    bus_out_d = op_a;
                    bus_rq_d  = 1'b1;
                    state_d   = S_SEND_A;
                end
            end
            S_SEND_A: begin
                bus_out_d = op_b_q;
                bus_rq_d  = 1'b1;
                state_d   = S_SEND_B;
            end
            S_SEND_B: begin
                bus_out_d = '0;
                bus_rq_d  = 1'b0;
                cnt_d     = WAIT_LOAD;
                // A one-edge wait has no WAIT edges at all: the next edge samples.
                state_d   = (WAIT_LOAD == 4'd0) ? S_CAPTURE : S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                result_d = bus.bus_result;
                done_d   = 1'b1;
                txn_d    = txn_q + 8'd1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            bus_out_q <= '0;
            bus_rq_q  <= 1'b0;
            cnt_q     <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
            txn_q     <= '0;
        end else begin
            state_q   <= state_d;
            bus_out_q <= bus_out_d;
            bus_rq_q  <= bus_rq_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            done_q    <= done_d;
            txn_q     <= txn_d;
        end
    end

    always_ff @(posedge clk) begin
        op_b_q <= op_b_d;
    end

    assign bus.bus_out = bus_out_q;
    assign bus.bus_rq  = bus_rq_q;
    assign result      = result_q;
    assign done        = done_q;
    assign busy        = (state_q != S_IDLE);
    assign txn_count   = txn_q;

endmodule

// File: tb/tb_alu_request_driver.sv
// Bench for alu_request_driver: three instances (RESULT_WAIT 3, 1, 0) share one
// stimulus stream; each has an adding consumer, a timing model and a scoreboard.
module tb_alu_request_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] op_a;
    logic [15:0] op_b;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] res;
        logic [7:0]  cnt;
        int          done_cyc;
    } exp_t;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int lane_id, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s lane%0d t=%0t: got 0x%0h, expected 0x%0h", nm, lane_id, $time, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : lane
        localparam int RW  = (g == 0) ? 3 : ((g == 1) ? 1 : 0);
        localparam int RWE = (RW < 1) ? 1 : RW;

        alu_request_driver_if #(.DATA_W(16)) bus ();
        logic [15:0] result;
        logic        done;
        logic        busy;
        logic [7:0]  txn_count;

        alu_request_driver #(.RESULT_WAIT(RW), .DATA_W(16)) dut (
            .clk       (clk),
            .reset     (reset),
            .start     (start),
            .op_a      (op_a),
            .op_b      (op_b),
            .bus       (bus),
            .result    (result),
            .done      (done),
            .busy      (busy),
            .txn_count (txn_count)
        );

        // Consumer in add mode: takes the first rq word, then the second, outputs the sum.
        logic [15:0] c_a;
        logic        c_phase;
        always @(posedge clk) begin
            if (reset) begin
                c_a            <= '0;
                c_phase        <= 1'b0;
                bus.bus_result <= '0;
            end else if (bus.bus_rq) begin
                if (!c_phase) begin
                    c_a     <= bus.bus_out;
                    c_phase <= 1'b1;
                end else begin
                    bus.bus_result <= c_a + bus.bus_out;
                    c_phase        <= 1'b0;
                end
            end
        end

        // Reference model: transaction-level timing computed from the accept edge.
        exp_t        q[$];
        int          mcyc     = 0;
        int          free_at  = 0;
        int          busy_end = -1;
        int          bus_k    = -10;
        int          epoch    = 0;
        logic [15:0] bus_a    = '0;
        logic [15:0] bus_b    = '0;
        logic [7:0]  mcount   = '0;

        initial begin
            forever begin
                exp_t item;
                @(posedge clk);
                mcyc++;
                if (reset) begin
                    q.delete();
                    free_at  = 0;
                    busy_end = -1;
                    bus_k    = -10;
                    mcount   = '0;
                    epoch++;
                end else if (start && mcyc >= free_at) begin
                    mcount        = mcount + 8'd1;
                    item.res      = op_a + op_b;
                    item.cnt      = mcount;
                    item.done_cyc = mcyc + 2 + RWE;
                    q.push_back(item);
                    bus_k    = mcyc;
                    bus_a    = op_a;
                    bus_b    = op_b;
                    busy_end = mcyc + 1 + RWE;
                    free_at  = mcyc + 3 + RWE;
                end
            end
        end

        // Monitor: compares every cycle, pops the scoreboard on each expected done.
        int          seen_epoch = 0;
        logic [15:0] exp_res    = '0;
        logic [7:0]  exp_cnt    = '0;

        initial begin
            forever begin
                exp_t        it;
                logic        exp_done;
                logic        exp_rq;
                logic [15:0] exp_out;
                @(negedge clk);
                if (epoch != seen_epoch) begin
                    seen_epoch = epoch;
                    exp_res    = '0;
                    exp_cnt    = '0;
                end
                exp_done = (q.size() != 0) && (q[0].done_cyc == mcyc);
                chk("done", g, 32'(done), 32'(exp_done));
                if (exp_done) begin
                    it      = q.pop_front();
                    exp_res = it.res;
                    exp_cnt = it.cnt;
                end
                exp_rq  = (mcyc == bus_k) || (mcyc == bus_k + 1);
                exp_out = (mcyc == bus_k) ? bus_a : ((mcyc == bus_k + 1) ? bus_b : 16'h0000);
                chk("result", g, 32'(result), 32'(exp_res));
                chk("txn_count", g, 32'(txn_count), 32'(exp_cnt));
                chk("busy", g, 32'(busy), 32'(mcyc <= busy_end));
                chk("bus_rq", g, 32'(bus.bus_rq), 32'(exp_rq));
                chk("bus_out", g, 32'(bus.bus_out), 32'(exp_out));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        repeat (3) step();
        reset = 1'b0;
        step();

        // Single transaction 5 + 3.
        start = 1'b1;
        op_a  = 16'h0005;
        op_b  = 16'h0003;
        step();
        start = 1'b0;
        op_a  = 16'hdead;
        op_b  = 16'hbeef;
        repeat (8) step();

        // start held high: back-to-back accepts on each done cycle.
        start = 1'b1;
        repeat (17) begin
            op_a = 16'($urandom);
            op_b = 16'($urandom);
            step();
        end
        start = 1'b0;
        repeat (8) step();

        // start pulsed during SEND_B and WAIT with fresh operands.
        start = 1'b1;
        op_a  = 16'h1234;
        op_b  = 16'h0101;
        step();
        start = 1'b0;
        step();
        start = 1'b1;
        op_a  = 16'hffff;
        op_b  = 16'h7777;
        step();
        op_a  = 16'h4444;
        step();
        start = 1'b0;
        repeat (8) step();

        // Reset during WAIT, then a clean transaction.
        start = 1'b1;
        op_a  = 16'h00aa;
        op_b  = 16'h0055;
        step();
        start = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        start = 1'b1;
        op_a  = 16'h8000;
        op_b  = 16'h8001;
        step();
        start = 1'b0;
        repeat (8) step();

        // Enough transactions to wrap txn_count past 255.
        start = 1'b1;
        repeat (260 * 6) begin
            op_a = 16'($urandom);
            op_b = 16'($urandom);
            step();
        end
        start = 1'b0;
        repeat (8) step();

        // Random start, operands and occasional reset.
        repeat (2000) begin
            start = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 79) == 0);
            op_a  = 16'($urandom);
            op_b  = 16'($urandom);
            step();
        end
        start = 1'b0;
        reset = 1'b0;
        repeat (30) step();

        chk("drain", 0, 32'(lane[0].q.size()), 32'd0);
        chk("drain", 1, 32'(lane[1].q.size()), 32'd0);
        chk("drain", 2, 32'(lane[2].q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
